cplx_dual_adder_pipe: RTL and testbench
=======================================

CPLX_DUAL_ADDER_PIPE -- requirements
Module: cplx_dual_adder_pipe

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 16, giving the width of every data input and output component.
REQ-002 The block SHALL have parameter SATURATE, default 1, where 1 means saturate on overflow and 0 means two's-complement wrap.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 Re_i1, Im_i1, Re_i2, Im_i2, Re_i3, Im_i3  input  BIT_WIDTH each  signed complex operands i1, i2, i3.
REQ-009 sub1, sub2  input  1 each  per-beat mode: 1 selects subtraction for output 1 and output 2 respectively.
REQ-010 scale_en  input  1  per-beat mode: 1 halves both results with rounding.
REQ-011 Re_o1, Im_o1, Re_o2, Im_o2  output  BIT_WIDTH each  signed registered results.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result beat.
REQ-014 ovf_clr  input  1  clears the sticky overflow flag.
REQ-015 ovf  output  1  sticky flag: at least one saturation or wrap has occurred since the last clear.

Function
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both 1; the data and mode bits (sub1, sub2, scale_en) SHALL travel with that beat through the pipeline.
REQ-017 Output 1 SHALL be i1+i3, or i1-i3 when sub1=1; output 2 SHALL be i1+i2, or i1-i2 when sub2=1; the same rule SHALL apply to the Re and Im components independently.
REQ-018 The sum SHALL be computed at full precision (BIT_WIDTH+1 bits) in stage 1 and registered.
REQ-019 In stage 2, when scale_en=1, the result SHALL be (sum+1)>>>1 (arithmetic shift, round half up); when scale_en=0, the sum SHALL pass unchanged.
REQ-020 Stage 2 SHALL then reduce the result to BIT_WIDTH: clamp to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1] when SATURATE=1, or keep the low BIT_WIDTH bits when SATURATE=0; the reduced result SHALL be registered onto the outputs.
REQ-021 Latency SHALL be 2 cycles from acceptance to out_valid, with out_ready held high; throughput SHALL be 1 beat per cycle.
REQ-022 Pipeline advance SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally; when adv=0, both stages SHALL hold.
REQ-023 While out_valid=1 and out_ready=0, all outputs SHALL stay stable; no beat SHALL be lost or duplicated.
REQ-024 When a valid beat's component falls out of range at the stage-2 reduction, ovf SHALL be set on the next clock edge.
REQ-025 ovf_clr SHALL clear ovf; if a set and a clear occur in the same cycle, the set SHALL take priority.
REQ-026 Bubbles (in_valid=0) SHALL propagate as stage-valid=0; a bubble SHALL never set ovf.

Reset
REQ-027 On rst, both stage-valid bits, out_valid, ovf and every data register SHALL go to 0 immediately, independent of clk.
REQ-028 After reset is released, in_ready SHALL be 1; the first beat SHALL be accepted on the first rising edge with in_valid=1.
REQ-029 A reset asserted mid-stream SHALL discard all in-flight beats; no stale beat SHALL appear after reset is released.

Structure
REQ-030 A shared package cplx_adder_pkg SHALL hold the default width constants and the min/max saturation constant functions of BIT_WIDTH.
REQ-031 One sub-module, cplx_round_sat, SHALL perform the stage-2 operation (optional rounding halve, then saturate/wrap, plus an overflow indication) for one component; it SHALL be instantiated 4 times.

Verification
REQ-032 Add path: Re_i1=100, Re_i3=20, Re_i2=-50, sub1=sub2=0, out_ready=1 -> 2 cycles later Re_o1=120, Re_o2=50, ovf=0.
REQ-033 Subtract path: Im_i1=10, Im_i2=30, sub2=1 -> Im_o2=-20.
REQ-034 Overflow: Re_i1=32767, Re_i3=1 -> with SATURATE=1, Re_o1=32767 and ovf=1; with SATURATE=0, Re_o1=-32768 and ovf=1.
REQ-035 Scaling: Re_i1=3, Re_i3=0, scale_en=1 -> Re_o1=2; Re_i1=-3 -> Re_o1=-1; Re_i1=32767, Re_i3=32767, scale_en=1 -> Re_o1=32767 and ovf=0.
REQ-036 Backpressure: stream 8 beats with out_ready low for 3 cycles mid-stream -> outputs held, in_ready=0 while stalled, all 8 results in order and unduplicated.
REQ-037 Control: assert rst with 2 beats in flight -> out_valid=0 immediately and no result emitted afterwards; assert ovf_clr in the same cycle as a new overflow -> ovf stays 1.

Source files
------------

// File: rtl/cplx_adder_pkg.sv
// Shared constants and saturation-bound helpers for the complex dual adder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package cplx_adder_pkg;

    localparam int DEF_BIT_WIDTH = 16;
    localparam bit DEF_SATURATE  = 1'b1;

    // Largest representable signed value of a w-bit word, as a wide signed constant.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/cplx_round_sat.sv
// One component of stage 2: optional round-half-up halve, then clamp or wrap to BIT_WIDTH.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module cplx_round_sat
    import cplx_adder_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter bit SATURATE  = DEF_SATURATE
) (
    input  logic signed [BIT_WIDTH:0]   i_sum,
    input  logic                        i_scale_en,
    output logic signed [BIT_WIDTH-1:0] o_res,
    output logic                        o_ovf
);

    localparam logic signed [63:0]          C_MAX64 = sat_max(BIT_WIDTH);
    localparam logic signed [63:0]          C_MIN64 = sat_min(BIT_WIDTH);
    localparam logic signed [BIT_WIDTH+1:0] C_MAX   = C_MAX64[BIT_WIDTH+1:0];
    localparam logic signed [BIT_WIDTH+1:0] C_MIN   = C_MIN64[BIT_WIDTH+1:0];
    localparam logic signed [BIT_WIDTH+1:0] C_ONE   = {{(BIT_WIDTH+1){1'b0}}, 1'b1};

    // Two guard bits: sum+1 of a full-scale difference needs one more bit than the sum.
    logic signed [BIT_WIDTH+1:0] w_ext;
    logic signed [BIT_WIDTH+1:0] w_inc;
    logic signed [BIT_WIDTH+1:0] w_half;
    logic signed [BIT_WIDTH+1:0] w_val;
    logic                        w_hi;
    logic                        w_lo;

    assign w_ext  = {i_sum[BIT_WIDTH], i_sum};
    assign w_inc  = w_ext + C_ONE;
    assign w_half = w_inc >>> 1;
    assign w_val  = i_scale_en ? w_half : w_ext;
    assign w_hi   = (w_val > C_MAX);
    assign w_lo   = (w_val < C_MIN);
    assign o_ovf  = w_hi | w_lo;

    always_comb begin
        o_res = w_val[BIT_WIDTH-1:0];
        if (SATURATE) begin
            if (w_hi) begin
                o_res = C_MAX[BIT_WIDTH-1:0];
            end else if (w_lo) begin
                o_res = C_MIN[BIT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/cplx_dual_adder_pipe.sv
// Two complex add/sub results (i1+-i3, i1+-i2) with optional halving and saturate/wrap.
// Latency: 2 cycles, 1 beat per cycle.
// Backpressure: in_ready = !out_valid || out_ready; both stages hold when it is low.
module cplx_dual_adder_pipe
    import cplx_adder_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter bit SATURATE  = DEF_SATURATE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] Re_i1,
    input  logic signed [BIT_WIDTH-1:0] Im_i1,
    input  logic signed [BIT_WIDTH-1:0] Re_i2,
    input  logic signed [BIT_WIDTH-1:0] Im_i2,
    input  logic signed [BIT_WIDTH-1:0] Re_i3,
    input  logic signed [BIT_WIDTH-1:0] Im_i3,
    input  logic                        sub1,
    input  logic                        sub2,
    input  logic                        scale_en,
    output logic signed [BIT_WIDTH-1:0] Re_o1,
    output logic signed [BIT_WIDTH-1:0] Im_o1,
    output logic signed [BIT_WIDTH-1:0] Re_o2,
    output logic signed [BIT_WIDTH-1:0] Im_o2,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        ovf_clr,
    output logic                        ovf
);

    logic w_adv;

    logic signed [BIT_WIDTH:0] w_re1_x, w_im1_x, w_re2_x, w_im2_x, w_re3_x, w_im3_x;
    logic signed [BIT_WIDTH:0] w_re_s1, w_im_s1, w_re_s2, w_im_s2;

    logic                      r_s1_vld;
    logic                      r_s1_scale;
    logic signed [BIT_WIDTH:0] r_s1_re1, r_s1_im1, r_s1_re2, r_s1_im2;

    logic signed [BIT_WIDTH-1:0] w_re1_res, w_im1_res, w_re2_res, w_im2_res;
    logic                        w_re1_ovf, w_im1_ovf, w_re2_ovf, w_im2_ovf;
    logic                        w_ovf_set;

    logic                        r_out_vld;
    logic signed [BIT_WIDTH-1:0] r_re_o1, r_im_o1, r_re_o2, r_im_o2;
    logic                        r_ovf;

    assign w_adv    = !r_out_vld || out_ready;
    assign in_ready = w_adv;

    // Sign-extend once so the add/sub below is exact at BIT_WIDTH+1 bits.
    assign w_re1_x = {Re_i1[BIT_WIDTH-1], Re_i1};
    assign w_im1_x = {Im_i1[BIT_WIDTH-1], Im_i1};
    assign w_re2_x = {Re_i2[BIT_WIDTH-1], Re_i2};
    assign w_im2_x = {Im_i2[BIT_WIDTH-1], Im_i2};
    assign w_re3_x = {Re_i3[BIT_WIDTH-1], Re_i3};
    assign w_im3_x = {Im_i3[BIT_WIDTH-1], Im_i3};

    assign w_re_s1 = sub1 ? (w_re1_x - w_re3_x) : (w_re1_x + w_re3_x);
    assign w_im_s1 = sub1 ? (w_im1_x - w_im3_x) : (w_im1_x + w_im3_x);
    assign w_re_s2 = sub2 ? (w_re1_x - w_re2_x) : (w_re1_x + w_re2_x);
    assign w_im_s2 = sub2 ? (w_im1_x - w_im2_x) : (w_im1_x + w_im2_x);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_scale <= 1'b0;
            r_s1_re1   <= '0;
            r_s1_im1   <= '0;
            r_s1_re2   <= '0;
            r_s1_im2   <= '0;
        end else if (w_adv) begin
            r_s1_vld   <= in_valid;
            r_s1_scale <= scale_en;
            r_s1_re1   <= w_re_s1;
            r_s1_im1   <= w_im_s1;
            r_s1_re2   <= w_re_s2;
            r_s1_im2   <= w_im_s2;
        end
    end

    cplx_round_sat #(.BIT_WIDTH(BIT_WIDTH), .SATURATE(SATURATE)) u_rs_re1 (
        .i_sum      (r_s1_re1),
        .i_scale_en (r_s1_scale),
        .o_res      (w_re1_res),
        .o_ovf      (w_re1_ovf)
    );

    cplx_round_sat #(.BIT_WIDTH(BIT_WIDTH), .SATURATE(SATURATE)) u_rs_im1 (
        .i_sum      (r_s1_im1),
        .i_scale_en (r_s1_scale),
        .o_res      (w_im1_res),
        .o_ovf      (w_im1_ovf)
    );

    cplx_round_sat #(.BIT_WIDTH(BIT_WIDTH), .SATURATE(SATURATE)) u_rs_re2 (
        .i_sum      (r_s1_re2),
        .i_scale_en (r_s1_scale),
        .o_res      (w_re2_res),
        .o_ovf      (w_re2_ovf)
    );

    cplx_round_sat #(.BIT_WIDTH(BIT_WIDTH), .SATURATE(SATURATE)) u_rs_im2 (
        .i_sum      (r_s1_im2),
        .i_scale_en (r_s1_scale),
        .o_res      (w_im2_res),
        .o_ovf      (w_im2_ovf)
    );

    // Only a real beat moving into the output register may raise the flag.
    assign w_ovf_set = w_adv && r_s1_vld && (w_re1_ovf || w_im1_ovf || w_re2_ovf || w_im2_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_re_o1   <= '0;
            r_im_o1   <= '0;
            r_re_o2   <= '0;
            r_im_o2   <= '0;
        end else if (w_adv) begin
            r_out_vld <= r_s1_vld;
            r_re_o1   <= w_re1_res;
            r_im_o1   <= w_im1_res;
            r_re_o2   <= w_re2_res;
            r_im_o2   <= w_im2_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign out_valid = r_out_vld;
    assign Re_o1     = r_re_o1;
    assign Im_o1     = r_im_o1;
    assign Re_o2     = r_re_o2;
    assign Im_o2     = r_im_o2;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cplx_dual_adder_pipe.sv
// Scoreboard bench: saturating and wrapping instances share stimulus and run in lockstep.
module tb_cplx_dual_adder_pipe;

    typedef struct {
        int a_re, a_im, b_re, b_im, c_re, c_im;
        bit s1, s2, sc;
        int e_r1, e_i1, e_r2, e_i2, w_r1;
    } vec_t;

    typedef struct {
        int r1, i1, r2, i2, w1;
    } exp_t;

    logic clk, rst;
    logic in_valid, in_ready, in_ready_w;
    logic signed [15:0] Re_i1, Im_i1, Re_i2, Im_i2, Re_i3, Im_i3;
    logic sub1, sub2, scale_en;
    logic signed [15:0] Re_o1, Im_o1, Re_o2, Im_o2;
    logic signed [15:0] w_Re_o1, w_Im_o1, w_Re_o2, w_Im_o2;
    logic out_valid, out_valid_w, out_ready, ovf_clr, ovf, ovf_w;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   st_lo = 0;
    int   st_hi = 0;
    exp_t sb[$];
    vec_t tbl[8];

    cplx_dual_adder_pipe #(.BIT_WIDTH(16), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2), .Re_i3(Re_i3), .Im_i3(Im_i3),
        .sub1(sub1), .sub2(sub2), .scale_en(scale_en),
        .Re_o1(Re_o1), .Im_o1(Im_o1), .Re_o2(Re_o2), .Im_o2(Im_o2),
        .out_valid(out_valid), .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf(ovf)
    );

    cplx_dual_adder_pipe #(.BIT_WIDTH(16), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2), .Re_i3(Re_i3), .Im_i3(Im_i3),
        .sub1(sub1), .sub2(sub2), .scale_en(scale_en),
        .Re_o1(w_Re_o1), .Im_o1(w_Im_o1), .Re_o2(w_Re_o2), .Im_o2(w_Im_o2),
        .out_valid(out_valid_w), .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf(ovf_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // out_ready is low only inside the [st_lo, st_hi) cycle window.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = !(cyc >= st_lo && cyc < st_hi);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.r1 = v.e_r1;
        e.i1 = v.e_i1;
        e.r2 = v.e_r2;
        e.i2 = v.e_i2;
        e.w1 = v.w_r1;
        return e;
    endfunction

    function automatic vec_t mk_vec(input int a_re, input int a_im, input int b_re, input int b_im,
                                    input int c_re, input int c_im, input bit s1, input bit s2,
                                    input bit sc, input int e_r1, input int e_i1, input int e_r2,
                                    input int e_i2, input int w_r1);
        vec_t v;
        v.a_re = a_re; v.a_im = a_im; v.b_re = b_re; v.b_im = b_im;
        v.c_re = c_re; v.c_im = c_im; v.s1 = s1; v.s2 = s2; v.sc = sc;
        v.e_r1 = e_r1; v.e_i1 = e_i1; v.e_r2 = e_r2; v.e_i2 = e_i2; v.w_r1 = w_r1;
        return v;
    endfunction

    task automatic send(input vec_t v, input bit push);
        int guard;
        @(negedge clk);
        Re_i1 = 16'(v.a_re); Im_i1 = 16'(v.a_im);
        Re_i2 = 16'(v.b_re); Im_i2 = 16'(v.b_im);
        Re_i3 = 16'(v.c_re); Im_i3 = 16'(v.c_im);
        sub1 = v.s1; sub2 = v.s2; scale_en = v.sc;
        in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", int'(in_ready), 1);
        end else if (push) begin
            sb.push_back(mk_exp(v));
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each handshake, checks held outputs across stalls.
    initial begin
        exp_t e;
        logic signed [15:0] h_r1, h_i1, h_r2, h_i2;
        bit have_hold;
        have_hold = 1'b0;
        h_r1 = '0; h_i1 = '0; h_r2 = '0; h_i2 = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                have_hold = 1'b0;
                continue;
            end
            if (have_hold) begin
                chk("hold_re1", int'(Re_o1), int'(h_r1));
                chk("hold_im1", int'(Im_o1), int'(h_i1));
                chk("hold_re2", int'(Re_o2), int'(h_r2));
                chk("hold_im2", int'(Im_o2), int'(h_i2));
                have_hold = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", int'(out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("re_o1", int'(Re_o1), e.r1);
                    chk("im_o1", int'(Im_o1), e.i1);
                    chk("re_o2", int'(Re_o2), e.r2);
                    chk("im_o2", int'(Im_o2), e.i2);
                    chk("wrap_vld", int'(out_valid_w), 1);
                    chk("wrap_re_o1", int'(w_Re_o1), e.w1);
                    chk("wrap_im_o1", int'(w_Im_o1), e.i1);
                    chk("wrap_re_o2", int'(w_Re_o2), e.r2);
                    chk("wrap_im_o2", int'(w_Im_o2), e.i2);
                end
            end else if (out_valid && !out_ready) begin
                chk("stall_in_ready", int'(in_ready), 0);
                h_r1 = Re_o1; h_i1 = Im_o1; h_r2 = Re_o2; h_i2 = Im_o2;
                have_hold = 1'b1;
            end
        end
    end

    initial begin
        vec_t v;
        //                a_re    a_im    b_re b_im c_re   c_im    s1 s2 sc  e_r1    e_i1    e_r2   e_i2    w_r1
        tbl[0] = mk_vec(100,    10,     -50, 30,  20,    5,      0, 0, 0,  120,    15,     50,    40,     120);
        tbl[1] = mk_vec(100,    10,     -50, 30,  20,    5,      0, 1, 0,  120,    15,     150,   -20,    120);
        tbl[2] = mk_vec(7,      -4,     1,   2,   9,     -6,     1, 0, 0,  -2,     2,      8,     -2,     -2);
        tbl[3] = mk_vec(3,      -3,     0,   0,   0,     0,      0, 0, 1,  2,      -1,     2,     -1,     2);
        tbl[4] = mk_vec(32767,  -32768, 1,   0,   32767, -32768, 0, 0, 1,  32767,  -32768, 16384, -16384, 32767);
        tbl[5] = mk_vec(-3,     5,      0,   -5,  0,     0,      0, 0, 1,  -1,     3,      -1,    0,      -1);
        tbl[6] = mk_vec(32767,  0,      0,   0,   1,     0,      0, 0, 0,  32767,  0,      32767, 0,      -32768);
        tbl[7] = mk_vec(-32768, 0,      0,   0,   1,     0,      1, 0, 0,  -32768, 0,      -32768, 0,     32767);

        rst = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
        Re_i1 = '0; Im_i1 = '0; Re_i2 = '0; Im_i2 = '0; Re_i3 = '0; Im_i3 = '0;
        sub1 = 1'b0; sub2 = 1'b0; scale_en = 1'b0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_re_o1", int'(Re_o1), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // First beat: output appears on the second edge after acceptance.
        send(tbl[0], 1'b1);
        chk("lat_s1_only", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", int'(out_valid), 1);
        chk("lat_re_o1", int'(Re_o1), 120);

        for (int i = 1; i <= 5; i++) send(tbl[i], 1'b1);
        drain();
        chk("no_ovf_sat", int'(ovf), 0);
        chk("no_ovf_wrap", int'(ovf_w), 0);

        send(tbl[6], 1'b1);
        drain();
        chk("ovf_sat", int'(ovf), 1);
        chk("ovf_wrap", int'(ovf_w), 1);

        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);

        // Clear lands on the same edge as a new overflow.
        send(tbl[7], 1'b1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("set_beats_clr_sat", int'(ovf), 1);
        chk("set_beats_clr_wrap", int'(ovf_w), 1);
        drain();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("ovf_cleared2", int'(ovf), 0);

        @(negedge clk);
        Re_i1 = 16'sd32767; Re_i3 = 16'sd1; sub1 = 1'b0; scale_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bubble_no_ovf", int'(ovf), 0);
        chk("bubble_no_vld", int'(out_valid), 0);

        st_lo = cyc + 3;
        st_hi = st_lo + 3;
        for (int k = 1; k <= 8; k++) begin
            v = mk_vec(10*k, -k, 2*k, k, k, 3, 1, 0, 0, 9*k, -k-3, 12*k, 0, 9*k);
            send(v, 1'b1);
        end
        drain();

        // Reset with one beat at the output and one in stage 1.
        send(tbl[0], 1'b0);
        send(tbl[1], 1'b0);
        chk("pre_rst_vld", int'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_re_o1", int'(Re_o1), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_no_vld", int'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
